// File: rtl/vts_pkg.sv
// ---------------------------------------------------------------------------
// vts_pkg
// Shared definitions for the vector test sequencer:
//   - vts_state_t : sequencer FSM state encoding
//   - EXP_LSB     : bit offset of the expected-value field in a vector word
//   - in_lsb()    : bit offset of the stimulus field (follows the expected field)
//   - last_bit()  : bit index of the end-of-test flag (the word's MSB)
//   - ERR_MAX     : saturation value of the mismatch counter
// Vector word layout, MSB to LSB: {last, inputs[IN_W], expected[OUT_W]}.
// ---------------------------------------------------------------------------
package vts_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } vts_state_t;

    localparam int          EXP_LSB = 0;
    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    function automatic int in_lsb(input int out_w);
        return EXP_LSB + out_w;
    endfunction

    function automatic int last_bit(input int in_w, input int out_w);
        return in_lsb(out_w) + in_w;
    endfunction

endpackage

// File: rtl/vts_err_counter.sv
// ---------------------------------------------------------------------------
// vts_err_counter
// Saturating mismatch counter with capture of the first failing address.
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous, active-low reset
//   clear          : synchronous clear at the start of a run
//   check          : a vector is being compared this cycle
//   mismatch       : the compared vector failed
//   addr           : address of the vector being compared
//   err_count      : number of mismatches, sticks at ERR_MAX
//   first_err_addr : address of the first mismatch of the run, 0 if none
// ---------------------------------------------------------------------------
module vts_err_counter
    import vts_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              check,
    input  logic              mismatch,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    // A zero count means no mismatch has been seen yet this run, so the
    // count itself tells us when to capture the first failing address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (clear) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (check && mismatch) begin
            if (err_count != ERR_MAX) begin
                err_count <= err_count + 16'd1;
            end
            if (err_count == '0) begin
                first_err_addr <= addr;
            end
        end
    end

endmodule

// File: rtl/vector_test_sequencer.sv
// ---------------------------------------------------------------------------
// vector_test_sequencer
// Walks a vector memory, applies each stimulus to an external DUT, waits
// SETTLE cycles, compares the DUT response against the stored expected value
// and reports pass/fail with error statistics.
// Optional build macro: VTS_STOP_ON_ERROR_EN -- when defined the run ends at
// the first mismatching vector; otherwise every vector up to the last flag or
// the end of memory is checked.
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous, active-low reset
//   start          : begin a run (only honoured in IDLE)
//   abort          : terminate the current run
//   vec_addr       : vector memory read address
//   vec_data       : {last, inputs, expected}, valid one cycle after vec_addr
//   dut_in         : registered stimulus to the DUT
//   dut_out        : DUT response
//   busy           : a run is in progress
//   done           : run finished, held until the next accepted start
//   pass           : valid with done; 1 when no mismatches were seen
//   err_count      : saturating mismatch count
//   vec_count      : vectors checked in the current or last run
//   first_err_addr : address of the first mismatching vector, 0 if none
// ---------------------------------------------------------------------------
module vector_test_sequencer
    import vts_pkg::*;
#(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     vec_addr,
    input  logic [IN_W+OUT_W:0]   vec_data,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_W:0]       vec_count,
    output logic [ADDR_W-1:0]     first_err_addr
);

    localparam int                IN_LSB      = in_lsb(OUT_W);
    localparam int                LAST_BIT    = last_bit(IN_W, OUT_W);
    localparam logic [ADDR_W-1:0] ADDR_MAX    = '1;
    // Only reachable when SETTLE > 0, so the wrap for SETTLE = 0 is harmless.
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

`ifdef VTS_STOP_ON_ERROR_EN
    localparam logic STOP_ON_ERR = 1'b1;
`else
    localparam logic STOP_ON_ERR = 1'b0;
`endif

    vts_state_t         state;
    logic [OUT_W-1:0]   exp_q;
    logic               last_q;
    logic [3:0]         settle_cnt;
    logic               in_check;
    logic               mismatch;
    logic               run_clear;
    logic               end_of_run;
    logic               run_active;

    assign in_check   = (state == S_CHECK);
    assign mismatch   = in_check && (dut_out != exp_q);
    // abort wins over start when both arrive together in IDLE
    assign run_clear  = (state == S_IDLE) && start && !abort;
    // the address never wraps: the top of memory always ends the run
    assign end_of_run = last_q || (vec_addr == ADDR_MAX) || (STOP_ON_ERR && mismatch);
    assign run_active = (state == S_FETCH) || (state == S_LOAD) ||
                        (state == S_SETTLE) || (state == S_CHECK);

    vts_err_counter #(
        .ADDR_W (ADDR_W)
    ) u_err_counter (
        .clk            (clk),
        .reset          (reset),
        .clear          (run_clear),
        .check          (in_check),
        .mismatch       (mismatch),
        .addr           (vec_addr),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    // Main sequencer. vec_addr doubles as the vector index; it is loaded on
    // entry to FETCH so the memory sees it during FETCH and returns the word
    // during LOAD. busy/done/pass are registered alongside the state so they
    // track it exactly. pass is resolved on the CHECK->DONE edge and has to
    // include the mismatch of the vector being checked in that same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            vec_addr   <= '0;
            dut_in     <= '0;
            exp_q      <= '0;
            last_q     <= 1'b0;
            settle_cnt <= '0;
            vec_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (abort && run_active) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_clear) begin
                        state     <= S_FETCH;
                        vec_addr  <= '0;
                        vec_count <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    dut_in     <= vec_data[IN_LSB +: IN_W];
                    exp_q      <= vec_data[EXP_LSB +: OUT_W];
                    last_q     <= vec_data[LAST_BIT];
                    settle_cnt <= '0;
                    state      <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    vec_count <= vec_count + 1'b1;
                    if (end_of_run) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        vec_addr <= vec_addr + 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_test_sequencer
// Bench for vector_test_sequencer. dut0 (SETTLE = 0) runs the scoreboarded
// sequences; dut1 (SETTLE = 3) exercises settle latency, start-while-busy
// and asynchronous reset mid-run. Both share one vector memory and a golden
// combinational DUT model y = (a & b) ^ c.
// ---------------------------------------------------------------------------
module tb_vector_test_sequencer;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 1;
    localparam int ADDR_W = 4;
    localparam int WORD_W = IN_W + OUT_W + 1;

    typedef struct {
        int   runId;
        logic pass;
        int   errCount;
        int   vecCount;
        int   firstErr;
        int   lastAddr;
        int   busyCycles;
    } expect_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, abort0, start1, abort1;

    logic [ADDR_W-1:0] vecAddr0, vecAddr1, firstErr0, firstErr1;
    logic [WORD_W-1:0] vecData0, vecData1;
    logic [IN_W-1:0]   dutIn0, dutIn1;
    logic [OUT_W-1:0]  dutOut0, dutOut1;
    logic              busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0]       errCount0, errCount1;
    logic [ADDR_W:0]   vecCount0, vecCount1;

    logic [WORD_W-1:0] vecMem [16];
    expect_t           sbQueue [$];

    int compares = 0;
    int fails    = 0;
    int busyCnt  = 0;
    logic donePrev = 1'b0;

    vector_test_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SETTLE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .vec_addr(vecAddr0), .vec_data(vecData0), .dut_in(dutIn0),
        .dut_out(dutOut0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(errCount0), .vec_count(vecCount0),
        .first_err_addr(firstErr0)
    );

    vector_test_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SETTLE(3)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .vec_addr(vecAddr1), .vec_data(vecData1), .dut_in(dutIn1),
        .dut_out(dutOut1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(errCount1), .vec_count(vecCount1),
        .first_err_addr(firstErr1)
    );

    function automatic logic goldenModel(input logic [2:0] x);
        return (x[2] & x[1]) ^ x[0];
    endfunction

    assign dutOut0 = goldenModel(dutIn0);
    assign dutOut1 = goldenModel(dutIn1);

    // Synchronous-read vector memory: data follows the address by one cycle.
    always @(posedge clk) begin
        vecData0 <= vecMem[vecAddr0];
        vecData1 <= vecMem[vecAddr1];
    end

    task automatic checkOutput(input string name, input int runId,
                               input int actual, input int expected);
        compares++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL run%0d %s: got %0d, expected %0d",
                     runId, name, actual, expected);
        end
    endtask

    // Vector i: inputs = i[2:0], expected = model (optionally flipped),
    // last flag only at lastAt (-1 = no last flag anywhere).
    task automatic loadMem(input int lastAt, input logic [15:0] flipMask);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            a = 4'(i);
            vecMem[i] = {(i == lastAt), a[2:0], goldenModel(a[2:0]) ^ flipMask[i]};
        end
    endtask

    task automatic waitDone0(input int runId, input int budget);
        int n = 0;
        while (!done0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done0) checkOutput("doneTimeout", runId, 0, 1);
    endtask

    task automatic applyStimulus(input expect_t e, input int lastAt,
                                 input logic [15:0] flipMask);
        loadMem(lastAt, flipMask);
        sbQueue.push_back(e);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("startAddr", e.runId, int'(vecAddr0), 0);
        checkOutput("startBusy", e.runId, int'(busy0), 1);
        waitDone0(e.runId, 200);
    endtask

    // Monitor: counts busy cycles and, on each rising done of dut0, pops the
    // next expectation and compares the final run results.
    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            if (busy0) begin
                busyCnt++;
            end else if (done0 && !donePrev) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedDone", -1, 1, 0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("pass",       e.runId, int'(pass0),     int'(e.pass));
                    checkOutput("errCount",   e.runId, int'(errCount0), e.errCount);
                    checkOutput("vecCount",   e.runId, int'(vecCount0), e.vecCount);
                    checkOutput("firstErr",   e.runId, int'(firstErr0), e.firstErr);
                    checkOutput("lastAddr",   e.runId, int'(vecAddr0),  e.lastAddr);
                    checkOutput("busyCycles", e.runId, busyCnt,         e.busyCycles);
                end
                busyCnt = 0;
            end else begin
                busyCnt = 0;
            end
            donePrev = done0;
        end
    end

    initial begin : stimulus
        int n;
        reset  = 1'b0;
        start0 = 1'b0;
        abort0 = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        loadMem(7, 16'h0000);
        repeat (3) @(negedge clk);

        checkOutput("rstBusy",     0, int'(busy0),     0);
        checkOutput("rstDone",     0, int'(done0),     0);
        checkOutput("rstPass",     0, int'(pass0),     0);
        checkOutput("rstErrCount", 0, int'(errCount0), 0);
        checkOutput("rstVecCount", 0, int'(vecCount0), 0);
        checkOutput("rstVecAddr",  0, int'(vecAddr0),  0);
        checkOutput("rstDutIn",    0, int'(dutIn0),    0);
        checkOutput("rstFirstErr", 0, int'(firstErr0), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: golden memory, last flag at 7.
        applyStimulus('{runId:1, pass:1'b1, errCount:0, vecCount:8,
                        firstErr:0, lastAddr:7, busyCycles:24}, 7, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("doneHeld", 1, int'(done0), 1);
        checkOutput("passHeld", 1, int'(pass0), 1);
        checkOutput("idleBusy", 1, int'(busy0), 0);

        // Run 2: expected values flipped at addresses 2 and 5.
`ifdef VTS_STOP_ON_ERROR_EN
        applyStimulus('{runId:2, pass:1'b0, errCount:1, vecCount:3,
                        firstErr:2, lastAddr:2, busyCycles:9}, 7, 16'h0024);
`else
        applyStimulus('{runId:2, pass:1'b0, errCount:2, vecCount:8,
                        firstErr:2, lastAddr:7, busyCycles:24}, 7, 16'h0024);
`endif
        repeat (2) @(negedge clk);

        // Run 3: no last flag, must stop at the top of memory.
        applyStimulus('{runId:3, pass:1'b1, errCount:0, vecCount:16,
                        firstErr:0, lastAddr:15, busyCycles:48}, -1, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("noWrapAddr", 3, int'(vecAddr0), 15);
        checkOutput("noWrapBusy", 3, int'(busy0),    0);

        // Run 4: abort while on vector 4.
        loadMem(7, 16'h0000);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (vecAddr0 != 4'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abortReach", 4, int'(vecAddr0), 4);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        checkOutput("abortBusy",     4, int'(busy0),     0);
        checkOutput("abortDone",     4, int'(done0),     0);
        checkOutput("abortVecCount", 4, int'(vecCount0), 4);
        repeat (2) @(negedge clk);
        checkOutput("abortStaysIdle", 4, int'(busy0), 0);

        // Run 5: rerun after abort starts again from address 0.
        applyStimulus('{runId:5, pass:1'b1, errCount:0, vecCount:8,
                        firstErr:0, lastAddr:7, busyCycles:24}, 7, 16'h0000);
        repeat (2) @(negedge clk);

        // start and abort together in IDLE: no run, done stays high.
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        checkOutput("startAbortBusy", 6, int'(busy0), 0);
        checkOutput("startAbortDone", 6, int'(done0), 1);
        repeat (2) @(negedge clk);
        checkOutput("startAbortStill", 6, int'(busy0), 0);

        // dut1, SETTLE = 3: every vector mismatches, 6 cycles per vector.
        loadMem(-1, 16'hFFFF);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("settleVecCount", 7, int'(vecCount1), 2);
        checkOutput("settleErrCount", 7, int'(errCount1), 2);
        checkOutput("settleVecAddr",  7, int'(vecAddr1),  2);
        checkOutput("settleBusy",     7, int'(busy1),     1);
        checkOutput("settleFirstErr", 7, int'(firstErr1), 0);
        repeat (2) @(negedge clk);
        checkOutput("settleDutIn",    7, int'(dutIn1),    2);

        // Asynchronous reset while dut1 sits in SETTLE.
        reset = 1'b0;
        #1;
        checkOutput("asyncBusy",     8, int'(busy1),     0);
        checkOutput("asyncDone",     8, int'(done1),     0);
        checkOutput("asyncPass",     8, int'(pass1),     0);
        checkOutput("asyncErrCount", 8, int'(errCount1), 0);
        checkOutput("asyncVecCount", 8, int'(vecCount1), 0);
        checkOutput("asyncVecAddr",  8, int'(vecAddr1),  0);
        checkOutput("asyncDutIn",    8, int'(dutIn1),    0);
        checkOutput("asyncFirstErr", 8, int'(firstErr1), 0);
        checkOutput("asyncDone0",    8, int'(done0),     0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("postRstBusy", 8, int'(busy1), 0);
        checkOutput("postRstDone", 8, int'(done1), 0);

        checkOutput("scoreboardDrained", -1, sbQueue.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
